// File: rtl/atm_session_ctrl_if.sv
// Signal bundle between the ATM session controller, the keypad/card front end and the
// shared session timer. The controller uses the master modport, the environment the slave one.
interface atm_session_ctrl_if;
    logic        card_in;
    logic        card_removed;
    logic        key_activity;
    logic        pin_valid;
    logic        pin_invalid;
    logic        txn_req;
    logic        txn_done;
    logic        cancel;
    logic        tmr_timeout;
    logic        tmr_start;
    logic        tmr_restart;
    logic [31:0] tmr_threshold;
    logic [2:0]  phase;
    logic        session_active;
    logic        eject_card;
    logic        retain_card;
    logic        abort;
    logic [2:0]  pin_tries;

    modport master (
        input  card_in, card_removed, key_activity, pin_valid, pin_invalid,
        input  txn_req, txn_done, cancel, tmr_timeout,
        output tmr_start, tmr_restart, tmr_threshold, phase, session_active,
        output eject_card, retain_card, abort, pin_tries
    );

    modport slave (
        output card_in, card_removed, key_activity, pin_valid, pin_invalid,
        output txn_req, txn_done, cancel, tmr_timeout,
        input  tmr_start, tmr_restart, tmr_threshold, phase, session_active,
        input  eject_card, retain_card, abort, pin_tries
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM card-session sequencer driving the shared session timer.
// Optional feature macro RETAIN_CARD_EN: timed EJECT and card retention after too many wrong PINs.
module atm_session_ctrl #(
    parameter logic [31:0] PIN_TIMEOUT   = 32'd3000,
    parameter logic [31:0] MENU_TIMEOUT  = 32'd3000,
    parameter logic [31:0] TXN_TIMEOUT   = 32'd6000,
    parameter logic [31:0] EJECT_TIMEOUT = 32'd1500,
    parameter int unsigned MAX_PIN_TRIES = 3
) (
    input logic                clk,
    input logic                rst,
    atm_session_ctrl_if.master bus
);

    localparam logic [2:0] MaxTries = 3'(MAX_PIN_TRIES);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPin    = 3'd1,
        StMenu   = 3'd2,
        StTxn    = 3'd3,
`ifdef RETAIN_CARD_EN
        StEject  = 3'd4,
        StRetain = 3'd5
`else
        StEject  = 3'd4
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        restart_q, restart_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic        active_q, active_d;
    logic        eject_q, eject_d;
    logic [31:0] thr_q, thr_d;
    logic [2:0]  tries_q, tries_d;
    logic [2:0]  tries_inc;
    logic        restart_evt;
    logic        timeout;

    function automatic logic is_timed(input state_e s);
`ifdef RETAIN_CARD_EN
        return (s == StPin) || (s == StMenu) || (s == StTxn) || (s == StEject);
`else
        return (s == StPin) || (s == StMenu) || (s == StTxn);
`endif
    endfunction

    function automatic logic [31:0] thr_for(input state_e s);
        case (s)
            StPin:   return PIN_TIMEOUT;
            StMenu:  return MENU_TIMEOUT;
            StTxn:   return TXN_TIMEOUT;
            StEject: return EJECT_TIMEOUT;
            default: return 32'd0;
        endcase
    endfunction

    // An expiry seen while the timer is being cleared belongs to the previous interval.
    assign timeout   = bus.tmr_timeout & ~restart_q;
    assign tries_inc = (tries_q == MaxTries) ? tries_q : tries_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        abort_d     = 1'b0;
        restart_evt = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.card_in) begin
                    state_d = StPin;
                    tries_d = 3'd0;
                end
            end
            StPin: begin
                if (bus.card_removed) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (bus.pin_invalid) begin
                    tries_d = tries_inc;
                    if (tries_inc == MaxTries) begin
`ifdef RETAIN_CARD_EN
                        state_d = StRetain;
`else
                        state_d = StEject;
`endif
                    end else begin
                        restart_evt = 1'b1;
                    end
                end else if (bus.pin_valid) begin
                    state_d = StMenu;
                end else if (bus.key_activity) begin
                    restart_evt = 1'b1;
                end else if (timeout) begin
                    state_d = StEject;
                    abort_d = 1'b1;
                end
            end
            StMenu: begin
                if (bus.card_removed) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (bus.txn_req) begin
                    state_d = StTxn;
                end else if (bus.cancel) begin
                    state_d = StEject;
                end else if (bus.key_activity) begin
                    restart_evt = 1'b1;
                end else if (timeout) begin
                    state_d = StEject;
                    abort_d = 1'b1;
                end
            end
            StTxn: begin
                if (bus.card_removed) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (bus.txn_done) begin
                    state_d = StMenu;
                end else if (timeout) begin
                    state_d = StEject;
                    abort_d = 1'b1;
                end
            end
            StEject: begin
                if (bus.card_removed) begin
                    state_d = StIdle;
`ifdef RETAIN_CARD_EN
                end else if (timeout) begin
                    state_d = StRetain;
                    abort_d = 1'b1;
`endif
                end
            end
`ifdef RETAIN_CARD_EN
            StRetain: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase

        // Registered outputs are computed from the next state so they line up with it.
        restart_d = restart_evt | ((state_d != state_q) & is_timed(state_d));
        thr_d     = restart_d ? thr_for(state_d) : thr_q;
        start_d   = is_timed(state_d);
        active_d  = (state_d != StIdle);
        eject_d   = (state_d == StEject);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            restart_q <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            active_q  <= 1'b0;
            eject_q   <= 1'b0;
            thr_q     <= 32'd0;
            tries_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            restart_q <= restart_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            active_q  <= active_d;
            eject_q   <= eject_d;
            thr_q     <= thr_d;
            tries_q   <= tries_d;
        end
    end

`ifdef RETAIN_CARD_EN
    logic retain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retain_q <= 1'b0;
        end else begin
            retain_q <= (state_d == StRetain);
        end
    end

    assign bus.retain_card = retain_q;
`else
    assign bus.retain_card = 1'b0;
`endif

    assign bus.phase          = state_q;
    assign bus.tmr_restart    = restart_q;
    assign bus.tmr_start      = start_q;
    assign bus.tmr_threshold  = thr_q;
    assign bus.abort          = abort_q;
    assign bus.session_active = active_q;
    assign bus.eject_card     = eject_q;
    assign bus.pin_tries      = tries_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed self-checking bench for atm_session_ctrl with a simple counting timer model.
module tb_atm_session_ctrl;

    localparam logic [31:0] PinTo  = 32'd10;
    localparam logic [31:0] MenuTo = 32'd3000;
    localparam logic [31:0] TxnTo  = 32'd6000;

    localparam logic [7:0] EvCardIn  = 8'h01;
    localparam logic [7:0] EvRemoved = 8'h02;
    localparam logic [7:0] EvKey     = 8'h04;
    localparam logic [7:0] EvPinOk   = 8'h08;
    localparam logic [7:0] EvPinBad  = 8'h10;
    localparam logic [7:0] EvTxnReq  = 8'h20;
    localparam logic [7:0] EvTxnDone = 8'h40;
    localparam logic [7:0] EvCancel  = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        to_ovr;
    logic [31:0] cnt;
    logic        model_to;
    int          n_cmp = 0;
    int          n_err = 0;

    atm_session_ctrl_if bus ();

    atm_session_ctrl #(
        .PIN_TIMEOUT(PinTo)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Timer model: clear on restart, count while enabled, flag when count reaches threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 32'd0;
        end else if (bus.tmr_restart) begin
            cnt <= 32'd0;
        end else if (bus.tmr_start) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign model_to        = bus.tmr_start && (cnt >= bus.tmr_threshold);
    assign bus.tmr_timeout = to_ovr | model_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply events for one clock starting at a negedge; returns at the next negedge.
    task automatic cyc(input logic [7:0] ev, input logic force_to);
        bus.card_in      = ev[0];
        bus.card_removed = ev[1];
        bus.key_activity = ev[2];
        bus.pin_valid    = ev[3];
        bus.pin_invalid  = ev[4];
        bus.txn_req      = ev[5];
        bus.txn_done     = ev[6];
        bus.cancel       = ev[7];
        to_ovr           = force_to;
        @(negedge clk);
        {bus.cancel, bus.txn_done, bus.txn_req, bus.pin_invalid} = 4'b0;
        {bus.pin_valid, bus.key_activity, bus.card_removed, bus.card_in} = 4'b0;
        to_ovr = 1'b0;
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        to_ovr = 1'b0;
        {bus.cancel, bus.txn_done, bus.txn_req, bus.pin_invalid} = 4'b0;
        {bus.pin_valid, bus.key_activity, bus.card_removed, bus.card_in} = 4'b0;
        repeat (2) @(negedge clk);
        check("rst_phase", 32'(bus.phase), 32'd0);
        check("rst_thr", bus.tmr_threshold, 32'd0);
        rst = 1'b0;

        // Happy path
        cyc(EvCardIn, 1'b0);
        check("hp_pin_phase", 32'(bus.phase), 32'd1);
        check("hp_pin_restart", 32'(bus.tmr_restart), 32'd1);
        check("hp_pin_thr", bus.tmr_threshold, PinTo);
        check("hp_pin_start", 32'(bus.tmr_start), 32'd1);
        check("hp_active", 32'(bus.session_active), 32'd1);
        cyc(8'h00, 1'b0);
        check("hp_restart_once", 32'(bus.tmr_restart), 32'd0);
        cyc(EvPinOk, 1'b0);
        check("hp_menu_phase", 32'(bus.phase), 32'd2);
        check("hp_menu_restart", 32'(bus.tmr_restart), 32'd1);
        check("hp_menu_thr", bus.tmr_threshold, MenuTo);
        cyc(EvTxnReq, 1'b0);
        check("hp_txn_phase", 32'(bus.phase), 32'd3);
        check("hp_txn_thr", bus.tmr_threshold, TxnTo);
        cyc(EvTxnDone, 1'b0);
        check("hp_menu2_phase", 32'(bus.phase), 32'd2);
        check("hp_menu2_restart", 32'(bus.tmr_restart), 32'd1);
        check("hp_menu2_thr", bus.tmr_threshold, MenuTo);
        cyc(EvCancel, 1'b0);
        check("hp_eject_phase", 32'(bus.phase), 32'd4);
        check("hp_eject_card", 32'(bus.eject_card), 32'd1);
        check("hp_eject_restart", 32'(bus.tmr_restart), 32'd0);
        check("hp_eject_thr_hold", bus.tmr_threshold, MenuTo);
        check("hp_eject_abort", 32'(bus.abort), 32'd0);
        cyc(EvRemoved, 1'b0);
        check("hp_idle_phase", 32'(bus.phase), 32'd0);
        check("hp_idle_abort", 32'(bus.abort), 32'd0);
        check("hp_idle_active", 32'(bus.session_active), 32'd0);

        // PIN timeout with a key restart at count 8
        cyc(EvCardIn, 1'b0);
        cyc(8'h00, 1'b0);
        n = 0;
        while (cnt != 32'd8 && n < 30) begin
            cyc(8'h00, 1'b0);
            n++;
        end
        check("to_reach_cnt8", cnt, 32'd8);
        cyc(EvKey, 1'b0);
        check("to_key_restart", 32'(bus.tmr_restart), 32'd1);
        check("to_key_phase", 32'(bus.phase), 32'd1);
        n = 0;
        while (bus.phase != 3'd4 && n < 40) begin
            cyc(8'h00, 1'b0);
            n++;
        end
        check("to_cycles", 32'(n), 32'd12);
        check("to_abort", 32'(bus.abort), 32'd1);
        cyc(8'h00, 1'b0);
        check("to_abort_1cyc", 32'(bus.abort), 32'd0);
        cyc(EvRemoved, 1'b0);

        // Wrong PIN three times
        cyc(EvCardIn, 1'b0);
        check("wp_tries_clr", 32'(bus.pin_tries), 32'd0);
        cyc(8'h00, 1'b0);
        cyc(EvPinBad, 1'b0);
        check("wp_tries1", 32'(bus.pin_tries), 32'd1);
        check("wp_restart1", 32'(bus.tmr_restart), 32'd1);
        cyc(EvPinBad | EvPinOk, 1'b0);
        check("wp_tries2", 32'(bus.pin_tries), 32'd2);
        check("wp_restart2", 32'(bus.tmr_restart), 32'd1);
        check("wp_both_stays_pin", 32'(bus.phase), 32'd1);
        cyc(EvPinBad, 1'b0);
        check("wp_tries3", 32'(bus.pin_tries), 32'd3);
`ifdef RETAIN_CARD_EN
        check("wp_retain_phase", 32'(bus.phase), 32'd5);
        check("wp_retain_pulse", 32'(bus.retain_card), 32'd1);
        cyc(8'h00, 1'b0);
        check("wp_retain_idle", 32'(bus.phase), 32'd0);
        check("wp_retain_1cyc", 32'(bus.retain_card), 32'd0);
`else
        check("wp_eject_phase", 32'(bus.phase), 32'd4);
        check("wp_no_retain", 32'(bus.retain_card), 32'd0);
        check("wp_eject_untimed", 32'(bus.tmr_start), 32'd0);
        cyc(EvRemoved, 1'b0);
`endif

        // Simultaneous events
        cyc(EvCardIn, 1'b0);
        check("si_tries_clr", 32'(bus.pin_tries), 32'd0);
        cyc(8'h00, 1'b0);
        cyc(EvPinOk, 1'b1);
        check("si_valid_vs_to", 32'(bus.phase), 32'd2);
        check("si_valid_no_abort", 32'(bus.abort), 32'd0);
        cyc(EvTxnReq, 1'b0);
        cyc(8'h00, 1'b0);
        cyc(EvRemoved | EvTxnDone, 1'b0);
        check("si_removed_phase", 32'(bus.phase), 32'd0);
        check("si_removed_abort", 32'(bus.abort), 32'd1);
        cyc(8'h00, 1'b0);
        check("si_abort_1cyc", 32'(bus.abort), 32'd0);

        // Stale timeout masked during the restart cycle on MENU entry
        cyc(EvCardIn, 1'b0);
        cyc(EvPinOk, 1'b0);
        check("st_restart_cycle", 32'(bus.tmr_restart), 32'd1);
        cyc(8'h00, 1'b1);
        check("st_masked_phase", 32'(bus.phase), 32'd2);
        check("st_masked_abort", 32'(bus.abort), 32'd0);
        cyc(8'h00, 1'b1);
        check("st_live_to_phase", 32'(bus.phase), 32'd4);
        check("st_live_to_abort", 32'(bus.abort), 32'd1);
        cyc(EvRemoved, 1'b0);

        // Asynchronous reset in MENU with a nonzero try count
        cyc(EvCardIn, 1'b0);
        cyc(EvPinBad, 1'b0);
        cyc(EvPinOk, 1'b0);
        check("ar_pre_phase", 32'(bus.phase), 32'd2);
        check("ar_pre_tries", 32'(bus.pin_tries), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_phase", 32'(bus.phase), 32'd0);
        check("ar_start", 32'(bus.tmr_start), 32'd0);
        check("ar_thr", bus.tmr_threshold, 32'd0);
        check("ar_restart", 32'(bus.tmr_restart), 32'd0);
        check("ar_active", 32'(bus.session_active), 32'd0);
        check("ar_tries", 32'(bus.pin_tries), 32'd0);
        check("ar_eject", 32'(bus.eject_card), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(8'h00, 1'b0);
        check("ar_stays_idle", 32'(bus.phase), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
